// File: rtl/systolic_array_os.sv
// Output-stationary ROWSxCOLS signed MAC array computing C = A*B over a runtime reduction length.
// Latency: first result row ROWS+COLS cycles after the last operand beat; 1 cycle after start when k_len==0.
// Backpressure: in_ready is high for the whole LOAD phase; result rows hold stable while out_ready is low.
//
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   start, k_len     job start (sampled in IDLE only) and reduction length latched with it
//   in_valid/in_ready, a_in_bus (slice r = A[r][k]), b_in_bus (slice c = B[k][c])
//   out_valid/out_ready, out_row_bus (slice c = C[row][c]), out_row_idx, out_last
//   busy (not IDLE), done (1-cycle pulse after the last row is accepted), ovf (sticky overflow)
//
// Build option: define SA_SATURATE_EN to clamp accumulators and report overflow on ovf;
// without it accumulation wraps modulo 2^ACC_W and ovf is tied low.
module systolic_array_os #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int K_W    = 16,
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [K_W-1:0]         k_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*DATA_W-1:0] a_in_bus,
    input  logic [COLS*DATA_W-1:0] b_in_bus,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COLS*ACC_W-1:0]  out_row_bus,
    output logic [IDX_W-1:0]       out_row_idx,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf
);

    localparam int FL_W = $clog2(ROWS + COLS);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_t;

    state_t state, state_nxt;

    logic [K_W-1:0]  k_lat;
    logic [K_W-1:0]  beat_cnt;
    logic [FL_W-1:0] flush_cnt;

    logic beat, last_beat, flush_end, row_acc, last_row;
    logic job_start, run;

    // Operands entering the skew (zero when no beat) and the skewed operands at the array edge.
    logic signed [DATA_W-1:0] a_src  [ROWS];
    logic signed [DATA_W-1:0] b_src  [COLS];
    logic signed [DATA_W-1:0] a_edge [ROWS];
    logic signed [DATA_W-1:0] b_edge [COLS];
    logic signed [DATA_W-1:0] a_sk   [ROWS][ROWS];
    logic signed [DATA_W-1:0] b_sk   [COLS][COLS];

    // Per-PE operand inputs, forwarding registers and accumulators.
    logic signed [DATA_W-1:0] a_pe   [ROWS][COLS];
    logic signed [DATA_W-1:0] b_pe   [ROWS][COLS];
    logic signed [DATA_W-1:0] a_pipe [ROWS][COLS];
    logic signed [DATA_W-1:0] b_pipe [ROWS][COLS];
    logic signed [ACC_W-1:0]  acc     [ROWS][COLS];
    logic signed [ACC_W-1:0]  acc_nxt [ROWS][COLS];

`ifdef SA_SATURATE_EN
    logic [ROWS*COLS-1:0] sat_flag;
    logic [ROWS*COLS-1:0] sat_hit;
`endif

    assign beat      = in_valid & in_ready;
    assign last_beat = beat && ((beat_cnt + K_W'(1)) == k_lat);
    assign flush_end = (flush_cnt == FL_W'(ROWS + COLS - 2));
    assign row_acc   = out_valid & out_ready;
    assign last_row  = (out_row_idx == IDX_W'(ROWS - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (k_len == '0) ? S_DRAIN : S_LOAD;
                end
            end
            S_LOAD: begin
                if (last_beat) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_end) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (row_acc && last_row) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state == S_LOAD);
        out_valid = (state == S_DRAIN);
        busy      = (state != S_IDLE);
        run       = (state == S_LOAD) || (state == S_FLUSH);
        job_start = (state == S_IDLE) && start;
        out_last  = (state == S_DRAIN) && last_row;
    end

    // ------------------------------------------------------------------
    // Job control: length latch, beat/flush counters, drain row index, done pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            k_lat       <= '0;
            beat_cnt    <= '0;
            flush_cnt   <= '0;
            out_row_idx <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (job_start) begin
                k_lat       <= k_len;
                beat_cnt    <= '0;
                flush_cnt   <= '0;
                out_row_idx <= '0;
            end
            if (beat) begin
                beat_cnt <= beat_cnt + K_W'(1);
            end
            if (state == S_FLUSH) begin
                flush_cnt <= flush_cnt + FL_W'(1);
            end
            if (row_acc) begin
                if (last_row) begin
                    out_row_idx <= '0;
                    done        <= 1'b1;
                end else begin
                    out_row_idx <= out_row_idx + IDX_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand unpacking; a cycle without a beat feeds zeros so it adds nothing.
    // ------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            a_src[r] = beat ? a_in_bus[r*DATA_W +: DATA_W] : '0;
        end
        for (int c = 0; c < COLS; c++) begin
            b_src[c] = beat ? b_in_bus[c*DATA_W +: DATA_W] : '0;
        end
    end

    // Skew taps: row r sees A delayed r cycles, column c sees B delayed c cycles,
    // so A[r][k] and B[k][c] meet in PE(r,c) exactly r+c cycles after beat k.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        if (r == 0) begin : g_direct
            assign a_edge[r] = a_src[r];
        end else begin : g_tap
            assign a_edge[r] = a_sk[r][r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        if (c == 0) begin : g_direct
            assign b_edge[c] = b_src[c];
        end else begin : g_tap
            assign b_edge[c] = b_sk[c][c-1];
        end
    end

    // PE operand sources: A hops right, B hops down, one register per hop.
    for (genvar r = 0; r < ROWS; r++) begin : g_pe_r
        for (genvar c = 0; c < COLS; c++) begin : g_pe_c
            if (c == 0) begin : g_a_edge
                assign a_pe[r][c] = a_edge[r];
            end else begin : g_a_hop
                assign a_pe[r][c] = a_pipe[r][c-1];
            end
            if (r == 0) begin : g_b_edge
                assign b_pe[r][c] = b_edge[c];
            end else begin : g_b_hop
                assign b_pe[r][c] = b_pipe[r-1][c];
            end
        end
    end

    // ------------------------------------------------------------------
    // MAC: full-precision signed product, sign-extended, then wrap or clamp.
    // ------------------------------------------------------------------
    always_comb begin
        logic signed [2*DATA_W-1:0] prod;
        logic signed [ACC_W-1:0]    pext;
`ifdef SA_SATURATE_EN
        logic [ACC_W:0]             sum_x;
        sat_hit = '0;
`endif
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                prod = (2*DATA_W)'(a_pe[r][c]) * (2*DATA_W)'(b_pe[r][c]);
                pext = ACC_W'(prod);
`ifdef SA_SATURATE_EN
                // One guard bit: overflow iff guard and sign disagree; guard gives the direction.
                sum_x = {acc[r][c][ACC_W-1], acc[r][c]} + {pext[ACC_W-1], pext};
                if (sum_x[ACC_W] != sum_x[ACC_W-1]) begin
                    sat_hit[r*COLS+c] = 1'b1;
                    acc_nxt[r][c] = sum_x[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                 : {1'b0, {(ACC_W-1){1'b1}}};
                end else begin
                    acc_nxt[r][c] = sum_x[ACC_W-1:0];
                end
`else
                acc_nxt[r][c] = acc[r][c] + pext;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers: cleared on reset and on job start, advance only in LOAD/FLUSH,
    // frozen in DRAIN so the drained rows stay stable.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || job_start) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int d = 0; d < ROWS; d++) begin
                    a_sk[r][d] <= '0;
                end
            end
            for (int c = 0; c < COLS; c++) begin
                for (int d = 0; d < COLS; d++) begin
                    b_sk[c][d] <= '0;
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    a_pipe[r][c] <= '0;
                    b_pipe[r][c] <= '0;
                    acc[r][c]    <= '0;
                end
            end
`ifdef SA_SATURATE_EN
            sat_flag <= '0;
`endif
        end else if (run) begin
            for (int r = 0; r < ROWS; r++) begin
                a_sk[r][0] <= a_src[r];
                for (int d = 1; d < ROWS; d++) begin
                    a_sk[r][d] <= a_sk[r][d-1];
                end
            end
            for (int c = 0; c < COLS; c++) begin
                b_sk[c][0] <= b_src[c];
                for (int d = 1; d < COLS; d++) begin
                    b_sk[c][d] <= b_sk[c][d-1];
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    a_pipe[r][c] <= a_pe[r][c];
                    b_pipe[r][c] <= b_pe[r][c];
                    acc[r][c]    <= acc_nxt[r][c];
                end
            end
`ifdef SA_SATURATE_EN
            sat_flag <= sat_flag | sat_hit;
`endif
        end
    end

`ifdef SA_SATURATE_EN
    assign ovf = |sat_flag;
`else
    assign ovf = 1'b0;
`endif

    // Row output is forced to zero outside DRAIN.
    always_comb begin
        out_row_bus = '0;
        if (out_valid) begin
            for (int c = 0; c < COLS; c++) begin
                out_row_bus[c*ACC_W +: ACC_W] = acc[out_row_idx][c];
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_os.sv
// Directed bench for systolic_array_os: a 32-bit-accumulator instance carries the main
// job table; a 16-bit-accumulator instance shares every input to exercise overflow.
module tb_systolic_array_os;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] k_len;
    logic        in_valid;
    logic [31:0] a_bus;
    logic [31:0] b_bus;
    logic        out_ready;

    logic         in_ready32, out_valid32, out_last32, busy32, done32, ovf32;
    logic [127:0] ob32;
    logic [1:0]   idx32;
    logic         in_ready16, out_valid16, out_last16, busy16, done16, ovf16;
    logic [63:0]  ob16;
    logic [1:0]   idx16;

    always #5 clk = ~clk;

    systolic_array_os #(.ROWS(4), .COLS(4), .DATA_W(8), .ACC_W(32), .K_W(16)) u_dut32 (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready32), .a_in_bus(a_bus), .b_in_bus(b_bus),
        .out_valid(out_valid32), .out_ready(out_ready), .out_row_bus(ob32),
        .out_row_idx(idx32), .out_last(out_last32), .busy(busy32), .done(done32), .ovf(ovf32)
    );

    systolic_array_os #(.ROWS(4), .COLS(4), .DATA_W(8), .ACC_W(16), .K_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready16), .a_in_bus(a_bus), .b_in_bus(b_bus),
        .out_valid(out_valid16), .out_ready(out_ready), .out_row_bus(ob16),
        .out_row_idx(idx16), .out_last(out_last16), .busy(busy16), .done(done16), .ovf(ovf16)
    );

`ifdef SA_SATURATE_EN
    localparam longint EXP16     = 32767;
    localparam longint EXP_OVF16 = 1;
`else
    localparam longint EXP16     = -32768;
    localparam longint EXP_OVF16 = 0;
`endif

    // Edges from the edge accepting the last beat to the first cycle with out_valid:
    // FLUSH lasts ROWS+COLS-1 cycles, so out_valid appears ROWS+COLS cycles after the beat cycle.
    localparam int EXP_LAT = 7;

    typedef struct {
        int k;
        bit gap;
        int stall;
        int a   [4][4];
        int b   [4][4];
        int exp [4][4];
    } vec_t;

    vec_t vecs [5];

    int ones  [4][4] = '{'{1,1,1,1}, '{1,1,1,1}, '{1,1,1,1}, '{1,1,1,1}};
    int twos  [4][4] = '{'{2,2,2,2}, '{2,2,2,2}, '{2,2,2,2}, '{2,2,2,2}};
    int ident [4][4] = '{'{1,0,0,0}, '{0,1,0,0}, '{0,0,1,0}, '{0,0,0,1}};
    int bseq  [4][4] = '{'{1,2,3,4}, '{5,6,7,8}, '{9,10,11,12}, '{13,14,15,16}};
    int a_sg  [4][4] = '{'{1,-1,0,0}, '{2,-1,0,0}, '{3,-1,0,0}, '{4,-1,0,0}};
    int b_sg  [4][4] = '{'{1,2,3,4}, '{3,3,3,3}, '{0,0,0,0}, '{0,0,0,0}};
    int c_sg  [4][4] = '{'{-2,-1,0,1}, '{-1,1,3,5}, '{0,3,6,9}, '{1,5,9,13}};
    int zeros [4][4] = '{'{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}};
    int neg   [4][4] = '{'{-128,-128,-128,-128}, '{-128,-128,-128,-128},
                         '{-128,-128,-128,-128}, '{-128,-128,-128,-128}};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint el32(input int c);
        return longint'($signed(ob32[c*32 +: 32]));
    endfunction

    function automatic longint el16(input int c);
        return longint'($signed(ob16[c*16 +: 16]));
    endfunction

    // Called at a negedge; returns at the negedge after the start edge. k_len is
    // scrambled afterwards so a design that fails to latch it loses the job.
    task automatic start_job(input int k);
        start = 1'b1;
        k_len = 16'(k);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k_len = 16'hFFFF;
    endtask

    // Feeds k beats; with gap set, every odd cycle carries no beat.
    task automatic feed(input int k, input bit gap, input int a [4][4], input int b [4][4],
                        output int rdy_bad);
        int kk  = 0;
        int cyc = 0;
        bit give;
        rdy_bad = 0;
        while (kk < k && cyc < 64) begin
            give     = !(gap && (cyc % 2 == 1));
            in_valid = give;
            for (int r = 0; r < 4; r++) a_bus[r*8 +: 8] = 8'(a[r][kk]);
            for (int c = 0; c < 4; c++) b_bus[c*8 +: 8] = 8'(b[kk][c]);
            if (in_ready32 !== 1'b1) rdy_bad++;
            @(posedge clk);
            if (give) kk++;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        a_bus    = '0;
        b_bus    = '0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid32 !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic drain(input int exp [4][4], input int stall);
        for (int row = 0; row < 4; row++) begin
            check("row_valid", out_valid32, 1);
            check("row_idx", idx32, row);
            check("row_last", out_last32, (row == 3) ? 1 : 0);
            for (int c = 0; c < 4; c++) check("row_data", el32(c), exp[row][c]);
            if (row == 1 && stall > 0) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    @(posedge clk);
                    @(negedge clk);
                    check("stall_valid", out_valid32, 1);
                    check("stall_idx", idx32, 1);
                    for (int c = 0; c < 4; c++) check("stall_data", el32(c), exp[1][c]);
                end
                out_ready = 1'b1;
            end
            check("done_early", done32, 0);
            @(posedge clk);
            @(negedge clk);
        end
        check("done_pulse", done32, 1);
        check("idle_busy", busy32, 0);
        check("idle_valid", out_valid32, 0);
        @(posedge clk);
        @(negedge clk);
        check("done_clear", done32, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rdy_bad;
        int lat;

        vecs[0].k = 1; vecs[0].gap = 0; vecs[0].stall = 0;
        vecs[0].a = ones;  vecs[0].b = twos; vecs[0].exp = twos;
        vecs[1].k = 4; vecs[1].gap = 0; vecs[1].stall = 0;
        vecs[1].a = ident; vecs[1].b = bseq; vecs[1].exp = bseq;
        vecs[2].k = 4; vecs[2].gap = 1; vecs[2].stall = 0;
        vecs[2].a = ident; vecs[2].b = bseq; vecs[2].exp = bseq;
        vecs[3].k = 4; vecs[3].gap = 0; vecs[3].stall = 5;
        vecs[3].a = ident; vecs[3].b = bseq; vecs[3].exp = bseq;
        vecs[4].k = 2; vecs[4].gap = 0; vecs[4].stall = 0;
        vecs[4].a = a_sg;  vecs[4].b = b_sg; vecs[4].exp = c_sg;

        rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
        a_bus = '0; b_bus = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        check("rst_in_ready", in_ready32, 0);
        check("rst_out_valid", out_valid32, 0);
        check("rst_out_last", out_last32, 0);
        check("rst_busy", busy32, 0);
        check("rst_done", done32, 0);
        check("rst_ovf", ovf32, 0);
        check("rst_idx", idx32, 0);
        check("rst_bus_zero", (ob32 == '0) ? 1 : 0, 1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            start_job(vecs[v].k);
            check("load_busy", busy32, 1);
            feed(vecs[v].k, vecs[v].gap, vecs[v].a, vecs[v].b, rdy_bad);
            check("in_ready_held", rdy_bad, 0);
            check("flush_ready_low", in_ready32, 0);
            wait_valid(lat);
            check("latency", lat, EXP_LAT);
            drain(vecs[v].exp, vecs[v].stall);
        end

        // Overflow: two steps of (-128)*(-128) = 32768 exceed a 16-bit accumulator.
        start_job(2);
        feed(2, 1'b0, neg, neg, rdy_bad);
        wait_valid(lat);
        check("ovf_latency", lat, EXP_LAT);
        check("ovf32_flag", ovf32, 0);
        check("ovf16_flag", ovf16, EXP_OVF16);
        check("ovf16_valid", out_valid16, 1);
        for (int row = 0; row < 4; row++) begin
            for (int c = 0; c < 4; c++) begin
                check("ovf32_data", el32(c), 32768);
                check("ovf16_data", el16(c), EXP16);
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("ovf_done", done16, 1);
        @(posedge clk);
        @(negedge clk);

        // Reset in the middle of DRAIN, then a zero-length job.
        start_job(4);
        feed(4, 1'b0, ident, bseq, rdy_bad);
        wait_valid(lat);
        @(posedge clk);
        @(negedge clk);
        check("mid_idx", idx32, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_valid", out_valid32, 0);
        check("abort_busy", busy32, 0);
        check("abort_idx", idx32, 0);
        check("abort_done", done32, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_job(0);
        check("k0_valid_next", out_valid32, 1);
        drain(zeros, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
